wb_stage_pipe: RTL and testbench



---
 rtl/wb_pipe_pkg.sv | 15 +
 rtl/wb_pipe_slot.sv | 25 ++
 rtl/wb_stage_pipe.sv | 96 +++++++++
 tb/tb_wb_stage_pipe.sv | 114 +++++++++++
 4 files changed

// File: rtl/wb_pipe_pkg.sv
// wb_pipe_pkg: shared types and constants for the MEM->WB pipeline register
package wb_pipe_pkg;
    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int DEPTH_MAX      = 4;
    typedef struct packed {
        logic                      regWrite;
        logic                      memToReg;
        logic [DATA_W_DEF-1:0]     writeData;
        logic [DATA_W_DEF-1:0]     readData;
        logic [DATA_W_DEF-1:0]     ALUResult;
        logic [REG_ADDR_W_DEF-1:0] regDst;
        logic [DATA_W_DEF-1:0]     pc;
    } wb_payload_t;
endpackage

// File: rtl/wb_pipe_slot.sv
// wb_pipe_slot: one pipeline stage holding a valid bit and an opaque payload
module wb_pipe_slot #(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         flush,
    input  logic         stall,
    input  logic         valid_d,
    input  logic [W-1:0] data_d,
    output logic         valid_q,
    output logic [W-1:0] data_q
);
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: DEPTH-stage MEM->WB register with valid, stall, flush and occupancy count
module wb_stage_pipe
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  regWrite_in,
    input  logic                  memToReg_in,
    input  logic [DATA_W-1:0]     readData_in,
    input  logic [DATA_W-1:0]     ALUResult_in,
    input  logic [REG_ADDR_W-1:0] regDst_in,
    input  logic [DATA_W-1:0]     pc_in,
    output logic                  valid_out,
    output logic                  regWrite_out,
    output logic                  memToReg_out,
    output logic [DATA_W-1:0]     writeData_out,
    output logic [DATA_W-1:0]     readData_out,
    output logic [DATA_W-1:0]     ALUResult_out,
    output logic [REG_ADDR_W-1:0] regDst_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [CNT_W-1:0]      valid_count
);
    // Same layout as wb_payload_t, widened to this instance's parameters.
    typedef struct packed {
        logic                  regWrite;
        logic                  memToReg;
        logic [DATA_W-1:0]     writeData;
        logic [DATA_W-1:0]     readData;
        logic [DATA_W-1:0]     ALUResult;
        logic [REG_ADDR_W-1:0] regDst;
        logic [DATA_W-1:0]     pc;
    } payload_t;

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("wb_stage_pipe: DEPTH must be in 1..%0d", DEPTH_MAX);
    end

    payload_t             in_p;
    payload_t             pd [DEPTH];
    payload_t             pq [DEPTH];
    logic     [DEPTH-1:0] vd;
    logic     [DEPTH-1:0] vq;
    logic     [DEPTH-1:0] vn;
    logic     [CNT_W-1:0] cnt_d;
    payload_t             last;

    assign in_p = '{regWrite_in, memToReg_in, memToReg_in ? readData_in : ALUResult_in,
                    readData_in, ALUResult_in, regDst_in, pc_in};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign vd[i] = valid_in;
            assign pd[i] = in_p;
        end else begin : g_body
            assign vd[i] = vq[i-1];
            assign pd[i] = pq[i-1];
        end
        wb_pipe_slot #(.W($bits(payload_t))) u_slot (
            .Clk    (Clk),
            .Rst    (Rst),
            .flush  (flush),
            .stall  (stall),
            .valid_d(vd[i]),
            .data_d (pd[i]),
            .valid_q(vq[i]),
            .data_q (pq[i])
        );
    end

    // Count mirrors the slots' next-state valid bits so it lines up with them.
    always_comb begin
        vn    = (Rst || flush) ? '0 : stall ? vq : vd;
        cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) cnt_d = cnt_d + CNT_W'(vn[k]);
    end

    always_ff @(posedge Clk) valid_count <= cnt_d;

    assign last          = pq[DEPTH-1];
    assign valid_out     = vq[DEPTH-1];
    assign regWrite_out  = valid_out & last.regWrite;
    assign memToReg_out  = valid_out & last.memToReg;
    assign writeData_out = valid_out ? last.writeData : '0;
    assign readData_out  = valid_out ? last.readData : '0;
    assign ALUResult_out = valid_out ? last.ALUResult : '0;
    assign regDst_out    = valid_out ? last.regDst : '0;
    assign pc_out        = valid_out ? last.pc : '0;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: drives DEPTH=1..4 instances in lockstep against an accept-history model
module tb_wb_stage_pipe;
    logic        clk, rst, stall, flush, valid_in, rw_in, m2r_in;
    logic [31:0] rd_in, alu_in, pc_in;
    logic [4:0]  dst_in;
    logic        vo [4];
    logic        rwo [4];
    logic        m2o [4];
    logic [31:0] wdo [4];
    logic [31:0] rdo [4];
    logic [31:0] alo [4];
    logic [31:0] pco [4];
    logic [4:0]  dso [4];
    logic [2:0]  vcnt [4];
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        v, rw, m;
        logic [31:0] rd, al, pc;
        logic [4:0]  ds;
    } ent_t;
    ent_t hist [2048];
    int   adv = 0;
    int   clr = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        logic [$clog2(g+1)-1:0] vc;
        wb_stage_pipe #(.DEPTH(g)) dut (
            .Clk(clk), .Rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
            .regWrite_in(rw_in), .memToReg_in(m2r_in), .readData_in(rd_in),
            .ALUResult_in(alu_in), .regDst_in(dst_in), .pc_in(pc_in),
            .valid_out(vo[g-1]), .regWrite_out(rwo[g-1]), .memToReg_out(m2o[g-1]),
            .writeData_out(wdo[g-1]), .readData_out(rdo[g-1]), .ALUResult_out(alo[g-1]),
            .regDst_out(dso[g-1]), .pc_out(pco[g-1]), .valid_count(vc)
        );
        assign vcnt[g-1] = 3'(vc);
    end

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL depth%0d %s: got %0h, want %0h (t=%0t)", d, tag, obs, exp, $time);
        end
    endtask

    // Output of a DEPTH-d pipe is the entry accepted d advances ago, unless cleared since.
    task automatic check_all();
        for (int d = 1; d <= 4; d++) begin
            int   idx = adv - d;
            bit   ok  = idx >= clr && hist[idx].v;
            ent_t e;
            int   n   = 0;
            e = ok ? hist[idx] : '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'h0};
            for (int k = (idx > clr ? idx : clr); k < adv; k++) n += int'(hist[k].v);
            chk(d, "valid_out", 32'(vo[d-1]), 32'(ok));
            chk(d, "regWrite_out", 32'(rwo[d-1]), 32'(e.rw));
            chk(d, "memToReg_out", 32'(m2o[d-1]), 32'(e.m));
            chk(d, "writeData_out", wdo[d-1], e.m ? e.rd : e.al);
            chk(d, "readData_out", rdo[d-1], e.rd);
            chk(d, "ALUResult_out", alo[d-1], e.al);
            chk(d, "regDst_out", 32'(dso[d-1]), 32'(e.ds));
            chk(d, "pc_out", pco[d-1], e.pc);
            chk(d, "valid_count", 32'(vcnt[d-1]), n);
        end
    endtask

    task automatic step(input logic r, f, s, v, rw, m, input logic [31:0] rd, al, pc, input logic [4:0] ds);
        rst = r; flush = f; stall = s; valid_in = v; rw_in = rw; m2r_in = m;
        rd_in = rd; alu_in = al; pc_in = pc; dst_in = ds;
        @(posedge clk);
        if (r || f) clr = adv;
        else if (!s) begin
            hist[adv] = '{v, rw, m, rd, al, pc, ds};
            adv++;
        end
        #1;
        check_all();
    endtask

    task automatic rstep(input logic r, f, s, v);
        step(r, f, s, v, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
    endtask

    initial begin
        repeat (2) rstep(1, 0, 0, 1);
        repeat (2) rstep(0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 32'h1234_5678, 32'h0000_00AA, 32'h40, 5'd9);
        step(0, 0, 0, 1, 1, 1, 32'h1234_5678, 32'h0000_00AA, 32'h44, 5'd9);
        repeat (4) rstep(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, $urandom, $urandom, 32'(4 * i), 5'(i + 1));
        repeat (2) rstep(0, 0, 1, 1);
        repeat (5) rstep(0, 0, 0, 0);
        repeat (4) rstep(0, 0, 0, 1);
        rstep(0, 1, 1, 1);
        repeat (2) rstep(0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, $urandom, $urandom, $urandom, 5'd31);
        repeat (2) rstep(0, 0, 0, 1);
        repeat (4) rstep(0, 0, 0, 0);
        repeat (4) rstep(0, 0, 0, 1);
        rstep(1, 0, 0, 1);
        repeat (5) rstep(0, 0, 0, 1);
        repeat (300) rstep(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 11) == 0),
                           1'($urandom_range(0, 3) == 0), 1'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
